// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift/add multiplier.
//   state_t       : FSM encoding (2'd3 is unused and treated as IDLE)
//   cnt_width()   : bit count of the RUN-cycle counter for a given operand width
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;

    // Counter must reach WIDTH, so it needs $clog2(WIDTH+1) bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation.
//   neg : 1 = output -in (mod 2^N), 0 = pass through
//   in  : N-bit operand
//   out : N-bit result
// Used for operand magnitudes (N=WIDTH) and for the final sign fix
// (N=2*WIDTH). The magnitude of the most negative value wraps to itself,
// which read as unsigned is exactly the right magnitude.
module cond_negate #(
    parameter int N = 4
) (
    input  logic         neg,
    input  logic [N-1:0] in,
    output logic [N-1:0] out
);

    assign out = neg ? (~in + N'(1)) : in;

endmodule

// File: rtl/tt_um_carlosgs99_seq_mult.sv
// Sequential shift/add multiplier with start/busy/done handshake.
//   io_clk     : clock, rising edge
//   io_rst     : synchronous active-high reset
//   io_start   : request, sampled only in IDLE
//   io_signed  : 1 = two's-complement operands, sampled with the operands
//   io_A/io_B  : multiplicand / multiplier (WIDTH bits)
//   io_busy    : high from the accept edge until the result edge
//   io_done    : one-cycle pulse when io_Product updates
//   io_Product : registered 2*WIDTH-bit result, holds until next completion
// Latency is WIDTH+1 cycles: WIDTH RUN cycles (one multiplier bit each,
// LSB first) plus one FINISH cycle that applies the sign correction.
module tt_um_carlosgs99_seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic               io_clk,
    input  logic               io_rst,
    input  logic               io_start,
    input  logic               io_signed,
    input  logic [WIDTH-1:0]   io_A,
    input  logic [WIDTH-1:0]   io_B,
    output logic               io_busy,
    output logic               io_done,
    output logic [2*WIDTH-1:0] io_Product
);

    import mult_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    state_t            state, state_nxt;
    logic              accept, in_run, in_finish;

    // Datapath {acc, mq}: acc collects partial sums, mq holds the
    // not-yet-consumed multiplier bits and fills with product LSBs.
    logic [WIDTH:0]    acc;
    logic [WIDTH-1:0]  mq;
    logic [WIDTH-1:0]  mcand;
    logic              neg;
    logic [CW-1:0]     cnt;

    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    addend, sum;
    logic [2*WIDTH-1:0] raw, prod_fix;

    // Operand magnitudes, only meaningful on the accept edge.
    cond_negate #(.N(WIDTH)) u_neg_a (
        .neg (io_signed & io_A[WIDTH-1]),
        .in  (io_A),
        .out (a_mag)
    );

    cond_negate #(.N(WIDTH)) u_neg_b (
        .neg (io_signed & io_B[WIDTH-1]),
        .in  (io_B),
        .out (b_mag)
    );

    // Magnitude product is < 2^(2*WIDTH), so acc's top bit is clear
    // after the final shift and raw needs only the low bits.
    assign raw = {acc[WIDTH-1:0], mq};

    cond_negate #(.N(2*WIDTH)) u_neg_p (
        .neg (neg),
        .in  (raw),
        .out (prod_fix)
    );

    // acc stays below 2^WIDTH before each add, so the WIDTH+1-bit sum
    // never overflows.
    assign addend = mq[0] ? {1'b0, mcand} : '0;
    assign sum    = acc + addend;

    // State register
    always_ff @(posedge io_clk) begin
        if (io_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and phase decode
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_run    = 1'b0;
        in_finish = 1'b0;
        case (state)
            ST_RUN: begin
                in_run = 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
                in_finish = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin  // ST_IDLE and the unused code
                if (io_start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
        endcase
    end

    // Datapath, counter and registered outputs
    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            acc        <= '0;
            mq         <= '0;
            mcand      <= '0;
            neg        <= 1'b0;
            cnt        <= '0;
            io_busy    <= 1'b0;
            io_done    <= 1'b0;
            io_Product <= '0;
        end else begin
            io_done <= 1'b0;
            if (accept) begin
                mcand   <= a_mag;
                mq      <= b_mag;
                acc     <= '0;
                neg     <= io_signed & (io_A[WIDTH-1] ^ io_B[WIDTH-1]);
                cnt     <= '0;
                io_busy <= 1'b1;
            end else if (in_run) begin
                // add-then-shift of the whole {acc, mq} register
                acc <= {1'b0, sum[WIDTH:1]};
                mq  <= {sum[0], mq[WIDTH-1:1]};
                cnt <= cnt + CW'(1);
            end else if (in_finish) begin
                io_Product <= prod_fix;
                io_done    <= 1'b1;
                io_busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tt_um_carlosgs99_seq_mult.sv
// Self-checking bench: a WIDTH=4 and a WIDTH=8 instance run side by side.
// A transaction-level model (accept -> result after WIDTH+1 edges, value
// from integer multiplication) is compared against busy/done/product on
// every cycle, plus directed literal checks from the test plan.
module tb_tt_um_carlosgs99_seq_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst   = 2'b11;
    logic [1:0]      start = 2'b00;
    logic [1:0]      sgn   = 2'b00;
    logic [1:0][7:0] a_i   = '0;
    logic [1:0][7:0] b_i   = '0;

    logic        busy4, done4, busy8, done8;
    logic [7:0]  prod4;
    logic [15:0] prod8;

    int n_tests = 0;
    int n_fail  = 0;

    tt_um_carlosgs99_seq_mult #(.WIDTH(4)) u_dut4 (
        .io_clk(clk), .io_rst(rst[0]), .io_start(start[0]), .io_signed(sgn[0]),
        .io_A(a_i[0][3:0]), .io_B(b_i[0][3:0]),
        .io_busy(busy4), .io_done(done4), .io_Product(prod4)
    );

    tt_um_carlosgs99_seq_mult #(.WIDTH(8)) u_dut8 (
        .io_clk(clk), .io_rst(rst[1]), .io_start(start[1]), .io_signed(sgn[1]),
        .io_A(a_i[1][7:0]), .io_B(b_i[1][7:0]),
        .io_busy(busy8), .io_done(done8), .io_Product(prod8)
    );

    // ---------------- reference model ----------------
    function automatic int wof(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a,
                                            input logic [7:0] b, input logic s);
        longint m, av, bv;
        m  = (longint'(1) << w) - 1;
        av = longint'(a) & m;
        bv = longint'(b) & m;
        if (s && ((av >> (w - 1)) & 1) == 1) av = av - (longint'(1) << w);
        if (s && ((bv >> (w - 1)) & 1) == 1) bv = bv - (longint'(1) << w);
        return 16'((av * bv) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    int          rem[2]    = '{0, 0};
    logic [15:0] pend[2]   = '{16'h0, 16'h0};
    logic [15:0] m_prod[2] = '{16'h0, 16'h0};
    logic        m_done[2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                rem[k] = 0; m_done[k] = 1'b0; m_prod[k] = 16'h0;
            end else begin
                m_done[k] = 1'b0;
                if (rem[k] == 0) begin
                    if (start[k]) begin
                        rem[k]  = wof(k) + 1;
                        pend[k] = ref_mul(wof(k), a_i[k], b_i[k], sgn[k]);
                    end
                end else begin
                    rem[k] = rem[k] - 1;
                    if (rem[k] == 0) begin
                        m_done[k] = 1'b1;
                        m_prod[k] = pend[k];
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: advance to the falling edge and compare both instances.
    task automatic tick();
        @(negedge clk);
        check("busy4", 16'(busy4), 16'(rem[0] != 0));
        check("done4", 16'(done4), 16'(m_done[0]));
        check("prod4", 16'(prod4), m_prod[0]);
        check("busy8", 16'(busy8), 16'(rem[1] != 0));
        check("done8", 16'(done8), 16'(m_done[1]));
        check("prod8", prod8, m_prod[1]);
    endtask

    function automatic logic get_done(input int k);
        return (k == 0) ? done4 : done8;
    endfunction

    function automatic logic [15:0] get_prod(input int k);
        return (k == 0) ? 16'(prod4) : prod8;
    endfunction

    // One operation from idle; checks the literal result and the latency.
    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [15:0] exp, input string name);
        int lat;
        start[k] = 1'b1; a_i[k] = a; b_i[k] = b; sgn[k] = s;
        tick();
        start[k] = 1'b0; a_i[k] = 8'($urandom); b_i[k] = 8'($urandom); sgn[k] = 1'($urandom);
        lat = 0;
        while (!get_done(k) && lat < 40) begin
            tick();
            lat++;
        end
        check({name, "_val"}, get_prod(k), exp);
        check({name, "_lat"}, 16'(lat), 16'(wof(k) + 1));
        tick();
        check({name, "_pulse"}, 16'(get_done(k)), 16'h0);
    endtask

    int dcount;

    initial begin
        // model pins
        check("ref_u15x15", ref_mul(4, 8'h0F, 8'h0F, 1'b0), 16'h00E1);
        check("ref_m8xm8",  ref_mul(4, 8'h08, 8'h08, 1'b1), 16'h0040);
        check("ref_m3x5",   ref_mul(4, 8'h0D, 8'h05, 1'b1), 16'h00F1);
        check("ref_7xm8",   ref_mul(4, 8'h07, 8'h08, 1'b1), 16'h00C8);
        check("ref8_m128",  ref_mul(8, 8'h80, 8'h80, 1'b1), 16'h4000);

        // reset state
        repeat (3) tick();
        rst = 2'b00;
        tick();
        check("rst_busy4", 16'(busy4), 16'h0);
        check("rst_prod4", 16'(prod4), 16'h0);
        check("rst_prod8", prod8, 16'h0);

        // directed WIDTH=4
        run_op(0, 8'h0F, 8'h0F, 1'b0, 16'h00E1, "u15x15");
        run_op(0, 8'h08, 8'h08, 1'b1, 16'h0040, "s_m8xm8");
        run_op(0, 8'h0D, 8'h05, 1'b1, 16'h00F1, "s_m3x5");
        run_op(0, 8'h07, 8'h08, 1'b1, 16'h00C8, "s_7xm8");
        run_op(0, 8'h00, 8'h09, 1'b0, 16'h0000, "zero");
        run_op(0, 8'h01, 8'h0D, 1'b0, 16'h000D, "ident");

        // start while busy is ignored
        start[0] = 1'b1; a_i[0] = 8'h03; b_i[0] = 8'h03; sgn[0] = 1'b0;
        tick();
        start[0] = 1'b0;
        tick();
        start[0] = 1'b1; a_i[0] = 8'h0F; b_i[0] = 8'h0F;
        tick();
        start[0] = 1'b0;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done4) dcount++;
            if (done4) check("busy_start_val", 16'(prod4), 16'h0009);
        end
        check("busy_start_ndone", 16'(dcount), 16'h1);

        // reset mid-operation
        start[0] = 1'b1; a_i[0] = 8'h0F; b_i[0] = 8'h0F;
        tick();
        start[0] = 1'b0;
        tick();
        tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("abort_busy", 16'(busy4), 16'h0);
        check("abort_prod", 16'(prod4), 16'h0);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done4) dcount++;
        end
        check("abort_nodone", 16'(dcount), 16'h0);
        run_op(0, 8'h0F, 8'h0F, 1'b0, 16'h00E1, "after_abort");

        // directed WIDTH=8
        run_op(1, 8'h80, 8'h80, 1'b1, 16'h4000, "w8_m128");
        run_op(1, 8'hFF, 8'hFF, 1'b0, 16'hFE01, "w8_u255");
        run_op(1, 8'h7F, 8'h80, 1'b1, 16'hC080, "w8_127xm128");

        // back-to-back with start held high
        repeat (12) tick();
        start = 2'b11;
        dcount = 0;
        for (int i = 0; i < 60; i++) begin
            a_i = {8'($urandom), 8'($urandom)};
            b_i = {8'($urandom), 8'($urandom)};
            sgn = 2'($urandom);
            tick();
            if (done4) dcount++;
        end
        start = 2'b00;
        check("b2b_count4", 16'(dcount), 16'd10);
        repeat (12) tick();

        // randomized sweep on both widths, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                start[k] = ($urandom_range(0, 2) == 0);
                sgn[k]   = 1'($urandom);
                a_i[k]   = 8'($urandom);
                b_i[k]   = 8'($urandom);
                rst[k]   = ($urandom_range(0, 96) == 0);
            end
            tick();
        end
        rst = 2'b00;
        start = 2'b00;
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
